// File: rtl/fifo_multi_port_banked.sv
// Multi-port FIFO: up to COUNT pushes and COUNT pops per cycle over COUNT banks.
// Entry k of the stream lives in bank k mod COUNT, and lanes are rotated onto banks by the pointer LSBs.
module fifo_multi_port_banked #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4,
  parameter int DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic [COUNT-1:0]             i_enq_valid,
  input  logic [WIDTH-1:0]             i_enq_data [0:COUNT-1],
  output logic                         o_enq_ready,
  input  logic [COUNT-1:0]             i_deq_ack,
  output logic [COUNT-1:0]             o_deq_valid,
  output logic [WIDTH-1:0]             o_deq_data [0:COUNT-1],
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int LOG = $clog2(COUNT);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NW  = LOG + 1;

  if ((COUNT < 2) || ((COUNT & (COUNT - 1)) != 0)) begin : g_bad_count
    $error("fifo_multi_port_banked: COUNT must be a power of two >= 2");
  end
  if ((DEPTH % COUNT) != 0) begin : g_bad_depth
    $error("fifo_multi_port_banked: DEPTH must be a multiple of COUNT");
  end

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]    w_count;
  logic [NW-1:0]    w_n_enq;
  logic [NW-1:0]    w_ack_run;
  logic [NW-1:0]    w_avail;
  logic [NW-1:0]    w_n_deq;
  logic             w_enq_fire;
  logic             w_run_e;
  logic             w_run_d;
  logic [COUNT-1:0] w_wr_we;
  logic [AW-1:0]    w_wr_idx  [COUNT];
  logic [WIDTH-1:0] w_wr_data [COUNT];

  assign w_count     = r_tail - r_head;
  assign o_count     = CW'(w_count);
  assign o_enq_ready = (w_count <= PW'(DEPTH - COUNT));
  assign w_enq_fire  = o_enq_ready & ~i_flush;

  // Only the unbroken run of requests starting at lane 0 counts.
  always_comb begin
    w_n_enq   = '0;
    w_ack_run = '0;
    w_run_e   = 1'b1;
    w_run_d   = 1'b1;
    for (int i = 0; i < COUNT; i++) begin
      w_run_e = w_run_e & i_enq_valid[i];
      w_run_d = w_run_d & i_deq_ack[i];
      if (w_run_e) w_n_enq = w_n_enq + NW'(1);
      if (w_run_d) w_ack_run = w_ack_run + NW'(1);
    end
  end

  assign w_avail = (w_count > PW'(COUNT)) ? NW'(COUNT) : w_count[NW-1:0];
  assign w_n_deq = (w_ack_run < w_avail) ? w_ack_run : w_avail;

  for (genvar b = 0; b < COUNT; b++) begin : g_bank
    logic [LOG-1:0] w_lane;
    assign w_lane       = LOG'(b) - r_tail[LOG-1:0];
    assign w_wr_we[b]   = w_enq_fire & ({1'b0, w_lane} < w_n_enq);
    assign w_wr_idx[b]  = r_tail[AW-1:0] + AW'(w_lane);
    assign w_wr_data[b] = i_enq_data[w_lane];
  end

  for (genvar i = 0; i < COUNT; i++) begin : g_lane
    logic [AW-1:0] w_rd_idx;
    assign w_rd_idx       = r_head[AW-1:0] + AW'(i);
    assign o_deq_data[i]  = r_mem[w_rd_idx];
    assign o_deq_valid[i] = (w_count > PW'(i));
  end

  // Storage is intentionally not reset; data is only observed when valid.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < COUNT; b++) begin
      if (w_wr_we[b]) r_mem[w_wr_idx[b]] <= w_wr_data[b];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(w_n_deq);
      if (w_enq_fire) r_tail <= r_tail + PW'(w_n_enq);
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush && i_enq_valid[0])
      assert (o_enq_ready) else $warning("enqueue request dropped: FIFO not ready");
  end
`endif

endmodule

// File: doc/fifo_multi_port_banked.md
Name: fifo_multi_port_banked

Overview:
- Multi-port FIFO: up to COUNT entries enqueued and up to COUNT dequeued per cycle.
- Storage is COUNT single-write banks. Entry k of the stream lives in bank (k mod COUNT).
- Lane-to-bank alignment is a rotate network: write side rotates by tail[LOG-1:0], read side by head[LOG-1:0] (LOG = $clog2(COUNT)), generalised to any power-of-two COUNT.
- Used as the wide instruction/uop buffer between fetch/decode stages.

Parameters:
WIDTH, 32, bits per entry
COUNT, 4, lanes per side; power of two, >= 2
DEPTH, 16, total entries; multiple of COUNT; DEPTH/COUNT power of two

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous clear of all entries
i_enq_valid  input  COUNT  per-lane enqueue request, lane 0 = oldest
i_enq_data  input  WIDTH x [0:COUNT-1] unpacked  enqueue data per lane
o_enq_ready  output  1  free slots >= COUNT
i_deq_ack  input  COUNT  per-lane dequeue acknowledge, lane 0 = oldest
o_deq_valid  output  COUNT  thermometer; lane i valid iff count > i
o_deq_data  output  WIDTH x [0:COUNT-1] unpacked  oldest entries, lane 0 = head
o_count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Pointers:
  - head and tail are $clog2(DEPTH)+1 bits, including a wrap bit. count = tail - head (modular).
  - Bank of lane i = (ptr + i) mod COUNT.
  - Row = ((ptr + i) / COUNT) mod (DEPTH/COUNT).
- Reset (async, i_rst_n low): head = tail = 0, o_count = 0, o_deq_valid = 0, o_enq_ready = 1. Storage is not reset; o_deq_data is don't-care while invalid.
- Enqueue:
  - n_enq = number of contiguous ones in i_enq_valid starting at lane 0. Lanes above the first zero are ignored (e.g. 1011 gives n_enq = 2).
  - Write occurs only if o_enq_ready = 1; otherwise the request is dropped and the producer must hold.
  - Lane i writes bank (tail+i) mod COUNT. tail += n_enq at the clock edge.
- Dequeue:
  - o_deq_data[i] = entry head+i, read combinationally from the registered array through the read rotate.
  - n_deq = number of contiguous ones in i_deq_ack from lane 0, clamped to popcount(o_deq_valid). Acks on invalid lanes are ignored.
  - head += n_deq at the clock edge.
- Ready and valid are derived from registered count only (no same-cycle bypass):
  - o_enq_ready = (DEPTH - count) >= COUNT.
  - A dequeue in the same cycle does not raise ready until the next cycle.
  - Enqueued data is visible on o_deq_data the cycle after the write; minimum latency is 1 cycle.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Allowed when full-minus-COUNT and when empty (an empty FIFO with enq and ack in the same cycle dequeues nothing).
- Flush has highest priority: head = tail = 0 next cycle; enqueue and dequeue in the same cycle are discarded.
- Wrap-around: pointers wrap modulo 2*DEPTH. Full is reached at count = DEPTH, which cannot be exceeded because of the ready rule.
- Reset asserted mid-operation: state clears immediately (asynchronously). Outputs take their reset values before the next edge.
- Assertions (simulation only):
  - COUNT is a power of two.
  - DEPTH mod COUNT == 0.
  - No enqueue is attempted while o_enq_ready = 0 (warning only).

Test Plan:
All scenarios use COUNT=4, DEPTH=16, WIDTH=32.
1. Reset: hold i_rst_n low 3 cycles, release -> o_count=0, o_enq_ready=1, o_deq_valid=0000. Assert i_rst_n low between clock edges mid-stream -> outputs return to these values before the next edge.
2. Enqueue rotation: valid=0111 with data 0xA,0xB,0xC, then valid=1111 with 0xD..0x10 -> o_count=7, o_deq_valid=1111, o_deq_data={0xA,0xB,0xC,0xD}.
3. Dequeue rotation: from (2), ack=0011 -> next cycle o_deq_data={0xC,0xD,0xE,0xF}, o_count=5. Then ack=1111 -> {0x10,x,x,x}, o_deq_valid=0001, o_count=1.
4. Full boundary:
   - Fill to 13 -> o_enq_ready=0.
   - Enqueue attempt while not ready -> dropped, o_count stays 13.
   - ack=0001 -> o_count=12, o_enq_ready=1 next cycle.
   - Enqueue 4 -> o_count=16, ready=0.
5. Wrap and ordering: 200 random cycles of random thermometer enq/ack with a scoreboard -> data order exact, no loss or duplication, o_count matches the model. Includes pointer wrap (>32 entries through) and non-thermometer masks such as enq=1011 (2 written) and ack=0101 (1 removed).
6. Flush: with o_count=9, assert i_flush together with enq=1111 and ack=1111 -> next cycle o_count=0, o_deq_valid=0000. A subsequent enqueue of 0x55 appears at lane 0.
